// File: rtl/apb_rr_master.sv
// apb_rr_master: two-requester APB master, round-robin grant, SETUP/ACCESS sequencing.
// Optional access timeout enabled by defining APB_TIMEOUT_EN.
module apb_rr_master #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_write,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [31:0]       paddr,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] gnt;
    logic [PW-1:0] gnt_next;
    logic          gnt_ok;

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] tmo_cnt;
`endif

    // First pending requester at or after the round-robin pointer
    always_comb begin
        int idx;
        idx    = 0;
        gnt    = '0;
        gnt_ok = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!gnt_ok && req_valid[idx]) begin
                gnt_ok = 1'b1;
                gnt    = PW'(idx);
            end
        end
        gnt_next = PW'((int'(gnt) + 1) % NREQ);
    end

    // Accept is offered only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !preset && gnt_ok) begin
            req_ready[gnt] = 1'b1;
        end
    end

    // Transfer sequencer with registered APB and response outputs
    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            rsp_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (gnt_ok) begin
                        pwrite  <= req_write[gnt];
                        paddr   <= req_addr[32*int'(gnt) +: 32];
                        pwdata  <= req_wdata[32*int'(gnt) +: 32];
                        owner   <= gnt;
                        rr_ptr  <= gnt_next;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (pready) begin
                        psel             <= 1'b0;
                        penable          <= 1'b0;
                        state            <= IDLE;
                        rsp_valid[owner] <= 1'b1;
                        rsp_err          <= pslverr;
                        rsp_rdata        <= pwrite ? 32'h0 : prdata;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tmo_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        psel             <= 1'b0;
                        penable          <= 1'b0;
                        state            <= IDLE;
                        rsp_valid[owner] <= 1'b1;
                        rsp_err          <= 1'b1;
                        rsp_rdata        <= 32'h0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master: random + directed stimulus, 4-register APB slave model,
// scoreboard of expected responses checked by an independent monitor.
module tb_apb_rr_master;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        preset;
    logic        rv [2];
    logic        rw [2];
    logic [31:0] ra [2];
    logic [31:0] rd [2];
    logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] rsp_rdata, paddr, pwdata, prdata;
    logic        rsp_err, psel, penable, pwrite, pready, pslverr;

    assign req_valid = {rv[1], rv[0]};
    assign req_write = {rw[1], rw[0]};
    assign req_addr  = {ra[1], ra[0]};
    assign req_wdata = {rd[1], rd[0]};

    apb_rr_master #(.NREQ(2), .TIMEOUT_CYC(T)) dut (
        .pclk(clk), .preset(preset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a < 32'h10) && (a[1:0] == 2'b00);
    endfunction

    // Slave model: configurable wait states, optional hang
    int          cfg_wait = 0;
    bit          hang = 1'b0;
    int          wcnt = 0;
    logic [31:0] smem [4];

    always @(posedge clk) begin
        #1;
        if (psel && !penable) begin
            wcnt = cfg_wait;
            pready = 1'b0;
            pslverr = 1'($urandom);
            prdata = $urandom;
        end else if (psel && penable) begin
            if (!hang && wcnt == 0) begin
                pready = 1'b1;
                pslverr = !addr_ok(paddr);
                if (pwrite) prdata = $urandom;
                else if (addr_ok(paddr)) prdata = smem[paddr[3:2]];
                else prdata = 32'h0;
            end else begin
                if (wcnt > 0) wcnt--;
                pready = 1'b0;
                pslverr = 1'($urandom);
                prdata = $urandom;
            end
        end else begin
            pready = 1'b0;
            pslverr = 1'b0;
            prdata = 32'h0;
        end
    end

    always @(negedge clk) begin
        if (psel && penable && pready && pwrite && addr_ok(paddr))
            smem[paddr[3:2]] = pwdata;
    end

    // Reference model and scoreboard
    typedef struct {
        int          owner;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb [$];
    int          gnt_log [$];
    logic [31:0] ref_mem [4];
    int          ptr_m = 0;
    int          phase = 0;
    int          acc_n = 0;
    logic        cur_w;
    logic [31:0] cur_a, cur_d;

    initial begin
        for (int i = 0; i < 4; i++) begin
            smem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
    end

    // Monitor: grant, APB phase and response checks each cycle
    always @(negedge clk) begin
        bit   idle_now;
        int   g;
        exp_t e;
        logic [1:0] exp_rdy;
        if (preset) begin
            chk("rst_req_ready", {62'h0, req_ready}, 64'h0);
            sb.delete();
            phase = 0;
            ptr_m = 0;
        end else begin
            idle_now = (phase == 0);
            if (sb.size() > 0 && cyc > sb[0].due) begin
                chk("rsp_missing_at", cyc, sb[0].due);
                void'(sb.pop_front());
            end
            if (rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {62'h0, rsp_valid}, 64'h0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_owner", {62'h0, rsp_valid}, 64'(2'b01 << e.owner));
                    chk("rsp_cycle", cyc, e.due);
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                end
            end
            case (phase)
                1: begin
                    chk("setup_phase", {psel, penable}, 2'b10);
                    chk("setup_addr", {pwrite, paddr, pwdata}, {cur_w, cur_a, cur_d});
                    phase = 2;
                    acc_n = 0;
                end
                2: begin
                    chk("access_phase", {psel, penable}, 2'b11);
                    chk("access_addr", {pwrite, paddr, pwdata}, {cur_w, cur_a, cur_d});
                    acc_n++;
                    if (pready) phase = 0;
`ifdef APB_TIMEOUT_EN
                    else if (acc_n == T) phase = 0;
`endif
                end
                default: chk("idle_bus", {psel, penable}, 2'b00);
            endcase
            g = -1;
            if (idle_now) begin
                if (req_valid[ptr_m]) g = ptr_m;
                else if (req_valid[1-ptr_m]) g = 1 - ptr_m;
            end
            exp_rdy = (g >= 0) ? 2'(2'b01 << g) : 2'b00;
            chk("req_ready", {62'h0, req_ready}, {62'h0, exp_rdy});
            if (g >= 0) begin
                ptr_m = (g + 1) % 2;
                cur_w = rw[g];
                cur_a = ra[g];
                cur_d = rd[g];
                gnt_log.push_back(g);
                phase = 1;
                e.owner = g;
                if (hang) begin
`ifdef APB_TIMEOUT_EN
                    e.rdata = 32'h0;
                    e.err = 1'b1;
                    e.due = cyc + 2 + T;
                    sb.push_back(e);
`endif
                end else begin
                    e.err = !addr_ok(cur_a);
                    e.rdata = (!cur_w && addr_ok(cur_a)) ? ref_mem[cur_a[3:2]] : 32'h0;
                    if (cur_w && addr_ok(cur_a)) ref_mem[cur_a[3:2]] = cur_d;
                    e.due = cyc + 3 + cfg_wait;
                    sb.push_back(e);
                end
            end
        end
    end

    // Requester agent: raise request, wait for accept, drop after the edge
    task automatic issue(input int i, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        int n;
        rv[i] = 1'b1;
        rw[i] = w;
        ra[i] = a;
        rd[i] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 300);
        chk("accepted", {63'h0, req_ready[i]}, 64'h1);
        @(posedge clk);
        #1;
        rv[i] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || phase != 0) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    logic [31:0] alist [6];

    initial begin
        alist[0] = 32'h0;  alist[1] = 32'h4;  alist[2] = 32'h8;
        alist[3] = 32'hC;  alist[4] = 32'h10; alist[5] = 32'h14;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rw[i] = 1'b0; ra[i] = '0; rd[i] = '0;
        end
        preset = 1'b1;
        rv[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_apb", {psel, penable, pwrite, paddr, pwdata}, '0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        preset = 1'b0;
        @(posedge clk);
        #1;

        cfg_wait = 0;
        issue(0, 1'b1, 32'h0, 32'h0000_00AB);
        drain();
        issue(1, 1'b1, 32'h4, 32'h2024_0101);
        drain();
        issue(1, 1'b0, 32'h4, 32'h0);
        drain();

        gnt_log.delete();
        fork
            begin repeat (2) issue(0, 1'b1, 32'h8, $urandom); end
            begin repeat (2) issue(1, 1'b0, 32'hC, 32'h0); end
        join
        drain();
        chk("alt_count", gnt_log.size(), 4);
        for (int k = 0; k < gnt_log.size(); k++)
            chk("alt_order", gnt_log[k], k % 2);

        cfg_wait = 1;
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        drain();
        issue(0, 1'b0, 32'h0, 32'h0);
        drain();

        for (int b = 0; b < 4; b++) begin
            cfg_wait = b;
            fork
                begin
                    for (int k = 0; k < 6; k++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        issue(0, 1'($urandom), alist[$urandom_range(0, 5)], $urandom);
                    end
                end
                begin
                    for (int k = 0; k < 6; k++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        issue(1, 1'($urandom), alist[$urandom_range(0, 5)], $urandom);
                    end
                end
            join
            drain();
        end

        cfg_wait = 0;
        hang = 1'b1;
        issue(0, 1'b0, 32'h4, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;
        @(negedge clk);
        chk("abort_bus", {psel, penable, rsp_valid}, 4'b0000);
        hang = 1'b0;
        @(posedge clk); #1;
        issue(1, 1'b0, 32'h4, 32'h0);
        drain();

        hang = 1'b1;
        issue(1, 1'b0, 32'h8, 32'h0);
`ifdef APB_TIMEOUT_EN
        repeat (12) begin @(posedge clk); #1; end
        chk("timeout_done", sb.size(), 0);
        hang = 1'b0;
`else
        repeat (100) begin
            @(negedge clk);
            chk("hold_psel", {63'h0, psel}, 64'h1);
        end
        @(posedge clk); #1;
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;
        hang = 1'b0;
`endif
        drain();
        issue(0, 1'b0, 32'h8, 32'h0);
        drain();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
